// File: rtl/keypad_bcd_packer_pkg.sv
// keypad_bcd_packer_pkg
//   Shared types and constants for the PIN-entry front end.
//   bcdPac_t : six BCD nibbles, index 0 (BCD0) is the least significant /
//              newest position; index 5 is BCD5.
//   entry_state_t : entry FSM states.
package keypad_bcd_packer_pkg;

  typedef logic [5:0][3:0] bcdPac_t;

  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hB;
  localparam logic [3:0] BCD_NONE  = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_SUBMIT = 2'd2
  } entry_state_t;

endpackage

// File: rtl/keypad_bcd_packer_cycle_timer.sv
// cycle_timer
//   Saturating cycle counter. Counts up while enabled and holds at LIMIT-1,
//   where o_expired is asserted. Restart, reset or a low enable force it to 0.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_enable       : count while high, held at 0 while low
//   i_restart      : return to 0 on the next edge
//   o_expired      : counter has reached LIMIT-1 (decoded from the register)
module cycle_timer #(
  parameter int LIMIT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/keypad_bcd_packer.sv
// keypad_bcd_packer
//   Assembles debounced keypad digits into a BCD packet. Drives a masked
//   display image (one dash per digit, newest digit briefly in clear) and
//   delivers the unmasked PIN on '#'. '*', timeout or reset discard the entry.
// Handshake: key_valid is a one-cycle strobe qualifying key_code; there is no
//   back-pressure, every strobe is consumed in its cycle. pin_valid and
//   pin_error are one-cycle pulses; pin_digits/pin_len are valid with pin_valid.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   key_valid, key_code    : key strobe and code (0-9 digit, A '*', B '#')
//   bcd_packet_operacional : display image
//   enable_o               : entry in progress (ENTRY or SUBMIT)
//   pin_digits, pin_len    : unmasked PIN buffer and its length
//   pin_valid, pin_error   : submit accepted / submit too short pulses
//   o_dbg_state            : current FSM state
module keypad_bcd_packer
  import keypad_bcd_packer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int MASK_CYCLES    = 50_000_000,
  parameter int MIN_DIGITS     = 4,
  parameter int MAX_DIGITS     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output bcdPac_t      bcd_packet_operacional,
  output logic         enable_o,
  output bcdPac_t      pin_digits,
  output logic [2:0]   pin_len,
  output logic         pin_valid,
  output logic         pin_error,
  output entry_state_t o_dbg_state
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_DIGITS);
  localparam logic [2:0] MIN_LEN = 3'(MIN_DIGITS);

  entry_state_t r_state;
  bcdPac_t      r_buf;
  logic [2:0]   r_len;
  logic         r_pin_valid;
  logic         r_pin_error;

  logic w_is_digit;
  logic w_run;
  logic w_tmo_restart;
  logic w_mask_restart;
  logic w_tmo_expired;
  logic w_mask_expired;

  assign w_is_digit = key_valid && (key_code <= 4'd9);
  assign w_run      = (r_state == ST_ENTRY);

  // Any digit (even one dropped at full length) keeps the entry alive, but
  // only an accepted digit brings a new digit into clear view.
  assign w_tmo_restart  = w_is_digit;
  assign w_mask_restart = w_is_digit && ((r_state == ST_IDLE) || (r_len < MAX_LEN));

  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (w_run),
    .i_restart (w_tmo_restart),
    .o_expired (w_tmo_expired)
  );

  cycle_timer #(.LIMIT(MASK_CYCLES)) u_mask (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (w_run),
    .i_restart (w_mask_restart),
    .o_expired (w_mask_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_buf       <= {6{BCD_NONE}};
      r_len       <= 3'd0;
      r_pin_valid <= 1'b0;
      r_pin_error <= 1'b0;
    end else begin
      r_pin_valid <= 1'b0;
      r_pin_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_digit) begin
            r_buf   <= {r_buf[4:0], key_code};
            r_len   <= 3'd1;
            r_state <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          // Digits and command keys take priority over a coincident timeout.
          if (w_is_digit) begin
            if (r_len < MAX_LEN) begin
              r_buf <= {r_buf[4:0], key_code};
              r_len <= r_len + 3'd1;
            end
          end else if (key_valid && (key_code == KEY_CLEAR)) begin
            r_buf   <= {6{BCD_NONE}};
            r_len   <= 3'd0;
            r_state <= ST_IDLE;
          end else if (key_valid && (key_code == KEY_ENTER)) begin
            if (r_len >= MIN_LEN) begin
              r_pin_valid <= 1'b1;
              r_state     <= ST_SUBMIT;
            end else begin
              r_pin_error <= 1'b1;
              r_buf       <= {6{BCD_NONE}};
              r_len       <= 3'd0;
              r_state     <= ST_IDLE;
            end
          end else if (w_tmo_expired) begin
            r_buf   <= {6{BCD_NONE}};
            r_len   <= 3'd0;
            r_state <= ST_IDLE;
          end
        end
        ST_SUBMIT: begin
          r_buf   <= {6{BCD_NONE}};
          r_len   <= 3'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_buf   <= {6{BCD_NONE}};
          r_len   <= 3'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Display image decoded from registers only.
  always_comb begin
    bcd_packet_operacional = {6{BCD_BLANK}};
    for (int i = 0; i < 6; i++) begin
      if (3'(i) >= r_len) begin
        bcd_packet_operacional[i] = BCD_BLANK;
      end else if ((i == 0) && !w_mask_expired) begin
        bcd_packet_operacional[i] = r_buf[0];
      end else begin
        bcd_packet_operacional[i] = BCD_DASH;
      end
    end
  end

  assign enable_o    = (r_state != ST_IDLE);
  assign pin_digits  = r_buf;
  assign pin_len     = r_len;
  assign pin_valid   = r_pin_valid;
  assign pin_error   = r_pin_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_bcd_packer.sv
module tb_keypad_bcd_packer;
  import keypad_bcd_packer_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         key_valid = 1'b0;
  logic [3:0]   key_code  = 4'h0;
  bcdPac_t      bcd_packet_operacional;
  logic         enable_o;
  bcdPac_t      pin_digits;
  logic [2:0]   pin_len;
  logic         pin_valid;
  logic         pin_error;
  entry_state_t dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  keypad_bcd_packer #(
    .TIMEOUT_CYCLES (20),
    .MASK_CYCLES    (5),
    .MIN_DIGITS     (4),
    .MAX_DIGITS     (6)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .key_valid              (key_valid),
    .key_code               (key_code),
    .bcd_packet_operacional (bcd_packet_operacional),
    .enable_o               (enable_o),
    .pin_digits             (pin_digits),
    .pin_len                (pin_len),
    .pin_valid              (pin_valid),
    .pin_error              (pin_error),
    .o_dbg_state            (dbg_state)
  );

  // driver tasks: every task returns 1 time unit after an active edge
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},    24'(enable_o),               24'h0);
    chk({tag, "_len"},   24'(pin_len),                24'h0);
    chk({tag, "_disp"},  bcd_packet_operacional,      24'hBBBBBB);
    chk({tag, "_pin"},   pin_digits,                  24'hFFFFFF);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    idle(2);
    chk_idle_outputs("reset");
    chk("reset_valid", 24'(pin_valid), 24'h0);
    chk("reset_error", 24'(pin_error), 24'h0);
    chk("reset_state", 24'(dbg_state), 24'(ST_IDLE));
    rst = 1'b0;
    idle(1);

    // ignored keys in IDLE
    press(4'hC);
    chk("idle_ign_en", 24'(enable_o), 24'h0);
    press(KEY_ENTER);
    chk("idle_enter_err", 24'(pin_error), 24'h0);
    chk("idle_enter_en", 24'(enable_o), 24'h0);

    // 1,2,3,4 spaced 10 cycles, then '#'
    press(4'd1);
    chk("d1_en",     24'(enable_o), 24'h1);
    chk("d1_len",    24'(pin_len),  24'h1);
    chk("d1_clear",  bcd_packet_operacional, 24'hBBBBB1);
    idle(3);
    chk("d1_still",  bcd_packet_operacional, 24'hBBBBB1);
    idle(1);
    chk("d1_mask",   bcd_packet_operacional, 24'hBBBBBA);
    idle(5);
    press(4'd2);
    chk("d2_clear",  bcd_packet_operacional, 24'hBBBBA2);
    idle(4);
    chk("d2_mask",   bcd_packet_operacional, 24'hBBBBAA);
    idle(5);
    press(4'd3);
    chk("d3_clear",  bcd_packet_operacional, 24'hBBBAA3);
    idle(4);
    chk("d3_mask",   bcd_packet_operacional, 24'hBBBAAA);
    idle(5);
    press(4'd4);
    chk("d4_clear",  bcd_packet_operacional, 24'hBBAAA4);
    idle(4);
    chk("d4_mask",   bcd_packet_operacional, 24'hBBAAAA);
    chk("d4_pin",    pin_digits, 24'hFF1234);
    press(KEY_ENTER);
    chk("sub_valid", 24'(pin_valid), 24'h1);
    chk("sub_pin",   pin_digits,     24'hFF1234);
    chk("sub_len",   24'(pin_len),   24'h4);
    chk("sub_en",    24'(enable_o),  24'h1);
    chk("sub_err",   24'(pin_error), 24'h0);
    idle(1);
    chk("post_valid", 24'(pin_valid), 24'h0);
    chk_idle_outputs("post_sub");

    // 7 digits back-to-back: length saturates, 7th restarts the timeout
    for (int d = 1; d <= 6; d++) press(4'(d));
    chk("max6_len",  24'(pin_len), 24'h6);
    chk("max6_pin",  pin_digits,   24'h123456);
    chk("max6_disp", bcd_packet_operacional, 24'hAAAAA6);
    press(4'd7);
    chk("max7_len",  24'(pin_len), 24'h6);
    chk("max7_pin",  pin_digits,   24'h123456);
    chk("max7_disp", bcd_packet_operacional, 24'hAAAAA6);
    idle(19);
    chk("max7_alive", 24'(enable_o), 24'h1);
    idle(1);
    chk_idle_outputs("max7_tmo");

    // 3 digits then '#': too short
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(KEY_ENTER);
    chk("short_err",   24'(pin_error), 24'h1);
    chk("short_valid", 24'(pin_valid), 24'h0);
    idle(1);
    chk("short_err2",  24'(pin_error), 24'h0);
    chk("short_valid2",24'(pin_valid), 24'h0);
    chk_idle_outputs("short");

    // 2 digits then idle: timeout at 20 cycles
    press(4'd5);
    press(4'd6);
    idle(19);
    chk("tmo_last", 24'(enable_o), 24'h1);
    idle(1);
    chk_idle_outputs("tmo");

    // key landing on the expiry cycle wins
    press(4'd5);
    press(4'd6);
    idle(19);
    press(4'd7);
    chk("tmo_key_en",   24'(enable_o), 24'h1);
    chk("tmo_key_len",  24'(pin_len),  24'h3);
    chk("tmo_key_disp", bcd_packet_operacional, 24'hBBBAA7);
    chk("tmo_key_pin",  pin_digits, 24'hFFF567);
    press(KEY_CLEAR);
    chk_idle_outputs("tmo_key_clr");

    // 5 digits then '*'
    for (int d = 0; d < 5; d++) press(4'(d));
    chk("star_len5", 24'(pin_len), 24'h5);
    press(KEY_CLEAR);
    chk("star_valid", 24'(pin_valid), 24'h0);
    chk("star_err",   24'(pin_error), 24'h0);
    chk_idle_outputs("star");
    idle(1);
    chk("star_valid2", 24'(pin_valid), 24'h0);

    // reset during ENTRY
    press(4'd3);
    press(4'd4);
    chk("rst_pre_len", 24'(pin_len), 24'h2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_valid", 24'(pin_valid), 24'h0);
    chk("rst_err",   24'(pin_error), 24'h0);
    chk_idle_outputs("rst_mid");
    idle(1);
    chk("rst_valid2", 24'(pin_valid), 24'h0);
    chk("rst_err2",   24'(pin_error), 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
